infeed_ctrl: RTL

INFEED_CTRL -- requirements
Module: infeed_ctrl

---
 rtl/systola_pkg.sv | 20 ++
 rtl/infeed_skew.sv | 43 ++++
 rtl/infeed_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/systola_pkg.sv
// Shared types and helpers for the systolic infeed path.
package systola_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter width able to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/infeed_skew.sv
// Drain read-mask generator: which row buffers pop at drain step t.
// INFEED_SKEW_EN selects the diagonal skew; otherwise all rows read together.
module infeed_skew
  import systola_pkg::*;
#(
  parameter int NROWS   = 4,
  parameter int TILELEN = 8,
  parameter int SCW     = 4
) (
  input  logic [SCW-1:0]   step,
  output logic [NROWS-1:0] mask,
  output logic             last
);

`ifdef INFEED_SKEW_EN
  localparam int NSTEPS = TILELEN + NROWS - 1;
`else
  localparam int NSTEPS = TILELEN;
`endif

  // Row r is scheduled while its TILELEN-long window covers the current step.
  always_comb begin
    mask = '0;
    for (int r = 0; r < NROWS; r++) begin
`ifdef INFEED_SKEW_EN
      if ((int'(step) >= r) && (int'(step) < r + TILELEN)) begin
        mask[r] = 1'b1;
      end else begin
        mask[r] = 1'b0;
      end
`else
      if (int'(step) < TILELEN) begin
        mask[r] = 1'b1;
      end else begin
        mask[r] = 1'b0;
      end
`endif
    end
  end

  assign last = (int'(step) == NSTEPS - 1);

endmodule

// File: rtl/infeed_ctrl.sv
// Infeed controller: loads one tile round-robin into NROWS row buffers, then drains
// them into the array rows. Optional macro INFEED_SKEW_EN enables the skewed drain.
module infeed_ctrl
  import systola_pkg::*;
#(
  parameter int NROWS   = 4,
  parameter int WORDLEN = 8,
  parameter int TILELEN = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDLEN-1:0] in_data,
  output logic [NROWS-1:0]   buf_write,
  output logic [WORDLEN-1:0] buf_din,
  input  logic [NROWS-1:0]   buf_full,
  input  logic [NROWS-1:0]   buf_empty,
  output logic [NROWS-1:0]   buf_read,
  output logic [NROWS-1:0]   arr_valid,
  output logic               busy,
  output logic               done
);

  localparam int NWORDS = NROWS * TILELEN;
  localparam int WCW    = cnt_width(NWORDS + 1);
  localparam int SCW    = cnt_width(TILELEN + NROWS);
  localparam int RPW    = cnt_width(NROWS);

  state_t           state_r;
  logic [WCW-1:0]   wcnt_r;
  logic [RPW-1:0]   rowptr_r;
  logic [SCW-1:0]   step_r;
  logic             busy_r;
  logic             done_r;

  logic             ready_s;
  logic             xfer_s;
  logic [NROWS-1:0] row_sel_s;
  logic [NROWS-1:0] sched_s;
  logic             last_step_s;
  logic             underrun_s;
  logic [NROWS-1:0] rd_s;

  infeed_skew #(
    .NROWS   (NROWS),
    .TILELEN (TILELEN),
    .SCW     (SCW)
  ) u_skew (
    .step (step_r),
    .mask (sched_s),
    .last (last_step_s)
  );

  // Load handshake and one-hot write strobe for the current row pointer.
  always_comb begin
    ready_s = (state_r == LOAD) && !buf_full[rowptr_r];
    xfer_s  = in_valid && ready_s;
    row_sel_s = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (xfer_s && (rowptr_r == RPW'(r))) begin
        row_sel_s[r] = 1'b1;
      end else begin
        row_sel_s[r] = 1'b0;
      end
    end
  end

  // An empty scheduled row freezes the whole drain so the skew stays aligned.
  always_comb begin
    underrun_s = |(sched_s & buf_empty);
    if ((state_r == DRAIN) && !underrun_s) begin
      rd_s = sched_s;
    end else begin
      rd_s = '0;
    end
  end

  assign in_ready  = ready_s;
  assign buf_write = row_sel_s;
  assign buf_din   = in_data;
  assign buf_read  = rd_s;
  assign arr_valid = rd_s;
  assign busy      = busy_r;
  assign done      = done_r;

  // Tile sequencing FSM with its counters and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      wcnt_r   <= '0;
      rowptr_r <= '0;
      step_r   <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r  <= LOAD;
            wcnt_r   <= '0;
            rowptr_r <= '0;
            step_r   <= '0;
            busy_r   <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer_s) begin
            wcnt_r <= wcnt_r + WCW'(1);
            if (rowptr_r == RPW'(NROWS - 1)) begin
              rowptr_r <= '0;
            end else begin
              rowptr_r <= rowptr_r + RPW'(1);
            end
            if (wcnt_r == WCW'(NWORDS - 1)) begin
              state_r <= DRAIN;
              step_r  <= '0;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        DRAIN: begin
          if (underrun_s) begin
            step_r <= step_r;
          end else if (last_step_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            step_r <= step_r + SCW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
